// File: rtl/ps2_keyboard_emulator.sv
// ps2_keyboard_emulator
//   Device-side PS/2 transmitter standing in for a keyboard. Scancode bytes are
//   queued and each one is serialised as an 11-bit PS/2 frame (start, 8 data bits
//   LSB first, odd parity, stop) on ps2_clk/ps2_dat, followed by an idle gap.
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   scancode_in     byte to transmit
//   scancode_valid  scancode_in is valid
//   scancode_ready  queue can accept a byte (taken on valid & ready at a clk edge)
//   host_inhibit    host is holding the PS/2 clock low (already synchronised)
//   ps2_clk         PS/2 clock toward the host, idle high (registered)
//   ps2_dat         PS/2 data toward the host, idle high (registered)
//   busy            a frame or post-frame gap is in progress (registered)
//   fifo_count      bytes queued, including the byte currently being sent
module ps2_keyboard_emulator #(
  parameter int CLK_HALF_PERIOD  = 2500,
  parameter int GAP_HALF_PERIODS = 4,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    scancode_in,
  input  logic                          scancode_valid,
  output logic                          scancode_ready,
  input  logic                          host_inhibit,
  output logic                          ps2_clk,
  output logic                          ps2_dat,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_HALF_PERIOD * GAP_HALF_PERIODS) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BIT_HI = 2'd1;
  localparam logic [1:0] ST_BIT_LO = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(CLK_HALF_PERIOD * GAP_HALF_PERIODS - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [PW:0]   DEPTH_COUNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   COUNT_ZERO  = {(PW+1){1'b0}};
  localparam logic [PW:0]   COUNT_ONE   = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO    = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE     = {{(PW-1){1'b0}}, 1'b1};

  localparam logic [3:0] BIT_START   = 4'd0;
  localparam logic [3:0] BIT_STOP    = 4'd10;
  localparam logic [3:0] BIT_LAST_AB = 4'd9;   // highest bit index an inhibit can abort

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Line level for frame bit position idx of byte d.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d);
    logic b;
    case (idx)
      4'd0:    b = 1'b0;
      4'd1:    b = d[0];
      4'd2:    b = d[1];
      4'd3:    b = d[2];
      4'd4:    b = d[3];
      4'd5:    b = d[4];
      4'd6:    b = d[5];
      4'd7:    b = d[6];
      4'd8:    b = d[7];
      4'd9:    b = odd_parity(d);
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic [1:0]    state_r;
  logic [3:0]    bit_idx_r;
  logic [CW-1:0] half_cnt_r;
  logic          ps2_clk_r;
  logic          ps2_dat_r;
  logic          busy_r;

  logic          ready_s;
  logic          push_s;
  logic          pop_s;
  logic [1:0]    state_s;
  logic [3:0]    bit_idx_s;
  logic [CW-1:0] half_cnt_s;
  logic          clk_line_s;
  logic          dat_line_s;
  logic          busy_s;
  logic          abort_s;
  logic [7:0]    head_s;

  // Ready is judged on the pre-pop count, so a full queue refuses a push even when a pop lands the same cycle.
  assign ready_s        = (count_r != DEPTH_COUNT);
  assign push_s         = scancode_valid & ready_s;
  assign head_s         = mem_r[rd_ptr_r];
  assign abort_s        = host_inhibit && (bit_idx_r <= BIT_LAST_AB);

  assign scancode_ready = ready_s;
  assign fifo_count     = count_r;
  assign ps2_clk        = ps2_clk_r;
  assign ps2_dat        = ps2_dat_r;
  assign busy           = busy_r;

  // Frame sequencing: next state, bit index, half-period counter and pop request.
  always_comb begin
    state_s    = state_r;
    bit_idx_s  = bit_idx_r;
    half_cnt_s = half_cnt_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != COUNT_ZERO) && !host_inhibit) begin
          state_s    = ST_BIT_HI;
          bit_idx_s  = BIT_START;
          half_cnt_s = HALF_LOAD;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_BIT_HI: begin
        if (abort_s) begin
          state_s    = ST_GAP;
          half_cnt_s = GAP_LOAD;
        end else if (half_cnt_r == CNT_ZERO) begin
          state_s    = ST_BIT_LO;
          half_cnt_s = HALF_LOAD;
        end else begin
          half_cnt_s = half_cnt_r - CNT_ONE;
        end
      end
      ST_BIT_LO: begin
        if (abort_s) begin
          state_s    = ST_GAP;
          half_cnt_s = GAP_LOAD;
        end else if (half_cnt_r == CNT_ZERO) begin
          if (bit_idx_r == BIT_STOP) begin
            // Stop bit's low phase is over: the byte has been delivered.
            pop_s      = 1'b1;
            state_s    = ST_GAP;
            half_cnt_s = GAP_LOAD;
          end else begin
            state_s    = ST_BIT_HI;
            bit_idx_s  = bit_idx_r + 4'd1;
            half_cnt_s = HALF_LOAD;
          end
        end else begin
          half_cnt_s = half_cnt_r - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (half_cnt_r == CNT_ZERO) begin
          state_s    = ST_IDLE;
        end else begin
          half_cnt_s = half_cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        bit_idx_s  = BIT_START;
        half_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // Line levels derived from the next state so the registered outputs track the FSM without lag.
  always_comb begin
    clk_line_s = (state_s != ST_BIT_LO);
    busy_s     = (state_s != ST_IDLE);
    if ((state_s == ST_BIT_HI) || (state_s == ST_BIT_LO)) begin
      dat_line_s = frame_bit(bit_idx_s, head_s);
    end else begin
      dat_line_s = 1'b1;
    end
  end

  // FSM state, counters and registered line outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      bit_idx_r  <= BIT_START;
      half_cnt_r <= CNT_ZERO;
      ps2_clk_r  <= 1'b1;
      ps2_dat_r  <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_idx_r  <= bit_idx_s;
      half_cnt_r <= half_cnt_s;
      ps2_clk_r  <= clk_line_s;
      ps2_dat_r  <= dat_line_s;
      busy_r     <= busy_s;
    end
  end

  // Queue pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= scancode_in;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_emulator.sv
// tb_ps2_keyboard_emulator
//   Directed bench: a small PS/2 host-side monitor decodes frames from the lines,
//   and each scenario compares against hand-computed frame words and timings.
//   Frame words hold bit 0 = start ... bit 10 = stop, in wire order.
module tb_ps2_keyboard_emulator;

  localparam int CHP   = 4;
  localparam int GAPHP = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] scancode_in = 8'h00;
  logic       scancode_valid = 1'b0;
  logic       host_inhibit = 1'b0;
  logic       scancode_ready;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       busy;
  logic [2:0] fifo_count;

  int assertions_evaluated = 0;
  int failures = 0;

  ps2_keyboard_emulator #(
    .CLK_HALF_PERIOD (CHP),
    .GAP_HALF_PERIODS(GAPHP),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .scancode_in   (scancode_in),
    .scancode_valid(scancode_valid),
    .scancode_ready(scancode_ready),
    .host_inhibit  (host_inhibit),
    .ps2_clk       (ps2_clk),
    .ps2_dat       (ps2_dat),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  // Host-side monitor: samples data on each ps2_clk fall, resyncs after a long clock-high stretch.
  int          mon_bitcnt = 0;
  int          mon_falls = 0;
  int          mon_high_run = 0;
  int          busy_cycles = 0;
  logic        mon_prev_clk = 1'b1;
  logic [10:0] mon_shift = 11'd0;
  logic [10:0] frames_q[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_bitcnt   = 0;
      mon_high_run = 0;
      mon_prev_clk = 1'b1;
    end else begin
      if (busy) busy_cycles++;
      if (mon_prev_clk && !ps2_clk) begin
        mon_falls++;
        mon_shift[mon_bitcnt] = ps2_dat;
        mon_bitcnt++;
        if (mon_bitcnt == 11) begin
          frames_q.push_back(mon_shift);
          mon_bitcnt = 0;
        end
      end
      if (ps2_clk) mon_high_run++;
      else mon_high_run = 0;
      if (mon_high_run > CHP + 1) mon_bitcnt = 0;
      mon_prev_clk = ps2_clk;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions_evaluated++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one byte for one cycle and checks the ready it sees.
  task automatic push(input logic [7:0] b, input logic exp_ready, input string tag);
    scancode_in    = b;
    scancode_valid = 1'b1;
    check_eq(tag, {31'd0, scancode_ready}, {31'd0, exp_ready});
    @(negedge clk);
    scancode_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((busy || fifo_count != 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {28'd0, busy, fifo_count}, 32'd0);
  endtask

  task automatic pop_frame(input string tag, input logic [10:0] exp);
    check_eq({tag, "_avail"}, (frames_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (frames_q.size() > 0) begin
      check_eq(tag, {21'd0, frames_q.pop_front()}, {21'd0, exp});
    end
  endtask

  // One byte into an idle block: start latency, pop point, frame length and frame contents.
  task automatic single_frame(input logic [7:0] b, input logic [10:0] exp, input string tag);
    int lat = 0;
    int t = 0;
    int pop_t = -1;
    int falls0;
    push(b, 1'b1, {tag, "_ready"});
    while (!busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_start_lat"}, lat, 32'd1);
    check_eq({tag, "_start_dat"}, {31'd0, ps2_dat}, 32'd0);
    check_eq({tag, "_count_start"}, {29'd0, fifo_count}, 32'd1);
    falls0 = mon_falls;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
      if (fifo_count == 3'd0 && pop_t < 0) pop_t = t;
    end
    check_eq({tag, "_busy_len"}, t, 32'd96);
    check_eq({tag, "_pop_at"}, pop_t, 32'd88);
    check_eq({tag, "_falls"}, mon_falls - falls0, 32'd11);
    pop_frame({tag, "_frame"}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f0;
    int b0;
    repeat (3) @(negedge clk);
    check_eq("rst_clk",   {31'd0, ps2_clk}, 32'd1);
    check_eq("rst_dat",   {31'd0, ps2_dat}, 32'd1);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_count", {29'd0, fifo_count}, 32'd0);
    check_eq("rst_ready", {31'd0, scancode_ready}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // 0x1C: data 0,0,1,1,1,0,0,0; parity 0
    single_frame(8'h1C, 11'h438, "t1");
    // 0xF0: data 0,0,0,0,1,1,1,1; parity 1
    single_frame(8'hF0, 11'h7E0, "t2");

    // Three bytes back to back
    b0 = busy_cycles;
    push(8'hF0, 1'b1, "t3_ready0");
    push(8'h1C, 1'b1, "t3_ready1");
    push(8'h2A, 1'b1, "t3_ready2");
    check_eq("t3_count", {29'd0, fifo_count}, 32'd3);
    wait_drain("t3_drain", 800);
    check_eq("t3_busy_cycles", busy_cycles - b0, 32'd288);
    pop_frame("t3_f0", 11'h7E0);
    pop_frame("t3_1c", 11'h438);
    pop_frame("t3_2a", 11'h454);

    // Inhibited host: queue fills, fifth byte refused, lines stay quiet
    host_inhibit = 1'b1;
    push(8'h11, 1'b1, "t4_ready0");
    push(8'h22, 1'b1, "t4_ready1");
    push(8'h33, 1'b1, "t4_ready2");
    push(8'h44, 1'b1, "t4_ready3");
    push(8'h55, 1'b0, "t4_ready_full");
    check_eq("t4_count_full", {29'd0, fifo_count}, 32'd4);
    f0 = mon_falls;
    repeat (40) @(negedge clk);
    check_eq("t4_no_falls", mon_falls - f0, 32'd0);
    check_eq("t4_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_idle_clk", {31'd0, ps2_clk}, 32'd1);
    check_eq("t4_count_hold", {29'd0, fifo_count}, 32'd4);
    host_inhibit = 1'b0;
    wait_drain("t4_drain", 1000);
    pop_frame("t4_11", 11'h622);
    pop_frame("t4_22", 11'h644);
    pop_frame("t4_33", 11'h666);
    pop_frame("t4_44", 11'h688);
    check_eq("t4_no_extra", frames_q.size(), 32'd0);

    // Abort 0x55 during bit 5, then resend the whole byte
    push(8'h55, 1'b1, "t5_ready");
    n = 0;
    while (mon_bitcnt != 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_reach_bit5", mon_bitcnt, 32'd6);
    check_eq("t5_pre_clk", {31'd0, ps2_clk}, 32'd0);
    host_inhibit = 1'b1;
    @(negedge clk);
    check_eq("t5_abort_clk", {31'd0, ps2_clk}, 32'd1);
    check_eq("t5_abort_dat", {31'd0, ps2_dat}, 32'd1);
    check_eq("t5_abort_count", {29'd0, fifo_count}, 32'd1);
    f0 = mon_falls;
    repeat (30) @(negedge clk);
    check_eq("t5_hold_falls", mon_falls - f0, 32'd0);
    check_eq("t5_hold_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_hold_count", {29'd0, fifo_count}, 32'd1);
    check_eq("t5_no_partial", frames_q.size(), 32'd0);
    host_inhibit = 1'b0;
    wait_drain("t5_drain", 400);
    pop_frame("t5_55", 11'h6AA);

    // Reset in the middle of a frame
    push(8'h77, 1'b1, "t6_ready");
    n = 0;
    while (ps2_clk && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_in_frame", {31'd0, ps2_clk}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_clk",   {31'd0, ps2_clk}, 32'd1);
    check_eq("t6_rst_dat",   {31'd0, ps2_dat}, 32'd1);
    check_eq("t6_rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("t6_rst_count", {29'd0, fifo_count}, 32'd0);
    check_eq("t6_rst_ready", {31'd0, scancode_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    f0 = mon_falls;
    repeat (30) @(negedge clk);
    check_eq("t6_post_busy",  {31'd0, busy}, 32'd0);
    check_eq("t6_post_falls", mon_falls - f0, 32'd0);
    check_eq("t6_post_clk",   {31'd0, ps2_clk}, 32'd1);
    check_eq("t6_post_count", {29'd0, fifo_count}, 32'd0);
    check_eq("t6_no_frame",   frames_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
    $finish;
  end

endmodule
